// File: rtl/uart_loader.sv
// uart_loader: boot-time program loader fed by the UART receive FIFO.
// Reads bytes from the UART data register, parses a framed image
// (SYNC, LEN_LO, LEN_HI, LEN x 4 data bytes LSB first, CKSUM) and writes
// assembled 32-bit words into instruction memory. The CPU is held in reset
// until a frame with a matching checksum has been accepted.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   restart         - synchronous re-arm pulse
//   rxFfEmpty       - UART receive FIFO empty
//   busAddr/busRdEn - UART register read port (address constant)
//   busDataIn/busOutEn - UART read data, valid one cycle after busRdEn
//   imemAddr/imemWrData/imemWrEn - instruction memory write port
//   cpuHold, busy, done, error   - status
module uart_loader #(
  parameter logic [10:0] UDR_ADDR       = 11'h402,
  parameter int unsigned IMEM_AW        = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               restart,
  input  logic               rxFfEmpty,
  output logic [10:0]        busAddr,
  output logic               busRdEn,
  input  logic [31:0]        busDataIn,
  input  logic               busOutEn,
  output logic [IMEM_AW-1:0] imemAddr,
  output logic [31:0]        imemWrData,
  output logic               imemWrEn,
  output logic               cpuHold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned MAX_WORDS = 1 << IMEM_AW;

  typedef enum logic [2:0] {
    S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CKSUM, S_DONE, S_ERROR
  } state_t;

  state_t             state_q, state_d;
  logic               rd_en_q, rd_en_d;
  logic               pend_q, pend_d;
  logic               drop_q, drop_d;
  logic [7:0]         len_lo_q, len_lo_d;
  logic [15:0]        len_q, len_d;
  logic [7:0]         cks_q, cks_d;
  logic [IMEM_AW:0]   wcnt_q, wcnt_d;
  logic [1:0]         bidx_q, bidx_d;
  logic [23:0]        word_q, word_d;
  logic [TW-1:0]      tcnt_q, tcnt_d;
  logic               we_q, we_d;
  logic [IMEM_AW-1:0] addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               hold_q, hold_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               cap;
  logic [7:0]         rx_byte;
  logic               in_frame;
  logic [IMEM_AW:0]   wcnt_next;
  logic               unused_bus_hi;

  // A returning byte is only taken if it answers a live read; restart drops it.
  assign cap           = busOutEn && pend_q && !drop_q && !restart;
  assign rx_byte       = busDataIn[7:0];
  assign in_frame      = state_q inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CKSUM};
  assign wcnt_next     = wcnt_q + 1'b1;
  assign unused_bus_hi = ^busDataIn[31:8];

  always_comb begin
    state_d  = state_q;
    rd_en_d  = 1'b0;
    pend_d   = pend_q;
    drop_d   = drop_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    cks_d    = cks_q;
    wcnt_d   = wcnt_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    tcnt_d   = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;

    // pend covers the cycle the data returns; the cycle after is the idle one
    if (rd_en_q) begin
      pend_d = 1'b1;
    end else if (busOutEn) begin
      pend_d = 1'b0;
      drop_d = 1'b0;
    end

    // Counter holds cycles since the last capture (1 in the cycle after it)
    if (in_frame) tcnt_d = cap ? TW'(1) : tcnt_q + TW'(1);

    case (state_q)
      S_WAIT_SYNC: if (cap && rx_byte == SYNC_BYTE) begin
        state_d = S_LEN_LO;
        cks_d   = '0;
        wcnt_d  = '0;
        bidx_d  = '0;
        err_d   = 1'b0;
        tcnt_d  = TW'(1);
      end
      S_LEN_LO: if (cap) begin
        len_lo_d = rx_byte;
        cks_d    = cks_q ^ rx_byte;
        state_d  = S_LEN_HI;
      end
      S_LEN_HI: if (cap) begin
        len_d = {rx_byte, len_lo_q};
        cks_d = cks_q ^ rx_byte;
        if (len_d == 16'd0) begin
          state_d = S_CKSUM;
        end else if (32'(len_d) > MAX_WORDS) begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: if (cap) begin
        cks_d = cks_q ^ rx_byte;
        if (bidx_q == 2'd3) begin
          we_d    = 1'b1;
          wdata_d = {rx_byte, word_q};
          addr_d  = wcnt_q[IMEM_AW-1:0];
          wcnt_d  = wcnt_next;
          bidx_d  = '0;
          if (32'(wcnt_next) == 32'(len_q)) state_d = S_CKSUM;
        end else begin
          word_d = {rx_byte, word_q[23:8]};
          bidx_d = bidx_q + 2'd1;
        end
      end
      S_CKSUM: if (cap) begin
        if (rx_byte == cks_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ERROR;
          err_d   = 1'b1;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_WAIT_SYNC;
      default: state_d = S_WAIT_SYNC;
    endcase

    if (in_frame && !cap && tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
    end

    if (restart) begin
      state_d = S_WAIT_SYNC;
      cks_d   = '0;
      wcnt_d  = '0;
      bidx_d  = '0;
      word_d  = '0;
      tcnt_d  = '0;
      err_d   = 1'b0;
      we_d    = 1'b0;
      // any read still in flight returns later and must be ignored
      drop_d  = pend_d;
    end

    rd_en_d = !restart && !rxFfEmpty && !rd_en_q && !pend_q &&
              (state_d inside {S_WAIT_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CKSUM});
    busy_d  = state_d inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CKSUM};
    done_d  = (state_d == S_DONE);
    hold_d  = (state_d != S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_WAIT_SYNC;
      rd_en_q  <= 1'b0;
      pend_q   <= 1'b0;
      drop_q   <= 1'b0;
      len_lo_q <= '0;
      len_q    <= '0;
      cks_q    <= '0;
      wcnt_q   <= '0;
      bidx_q   <= '0;
      word_q   <= '0;
      tcnt_q   <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_en_q  <= rd_en_d;
      pend_q   <= pend_d;
      drop_q   <= drop_d;
      len_lo_q <= len_lo_d;
      len_q    <= len_d;
      cks_q    <= cks_d;
      wcnt_q   <= wcnt_d;
      bidx_q   <= bidx_d;
      word_q   <= word_d;
      tcnt_q   <= tcnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busAddr    = UDR_ADDR;
  assign busRdEn    = rd_en_q;
  assign imemAddr   = addr_q;
  assign imemWrData = wdata_q;
  assign imemWrEn   = we_q;
  assign cpuHold    = hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Bench for uart_loader: a UART FIFO responder feeds directed byte streams,
// a frame-level model predicts the memory writes and final status, and a
// per-cycle monitor compares writes and status timing against it.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        rst, restart, rxFfEmpty, busOutEn;
  logic [31:0] busDataIn;
  logic [10:0] busAddr;
  logic        busRdEn, imemWrEn, cpuHold, busy, done, error;
  logic [9:0]  imemAddr;
  logic [31:0] imemWrData;

  uart_loader #(
    .UDR_ADDR(11'h402), .IMEM_AW(10), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .rxFfEmpty(rxFfEmpty),
    .busAddr(busAddr), .busRdEn(busRdEn), .busDataIn(busDataIn),
    .busOutEn(busOutEn), .imemAddr(imemAddr), .imemWrData(imemWrData),
    .imemWrEn(imemWrEn), .cpuHold(cpuHold), .busy(busy), .done(done),
    .error(error)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { logic [9:0] addr; logic [31:0] data; } wr_t;

  int unsigned n_checks = 0, n_pass = 0;
  int          cyc = 0;
  logic [7:0]  rx_q[$];
  wr_t         exp_wr[$], act_wr[$];
  logic        exp_done, exp_error;
  int          last_cap_cyc = 0, sync_cap_cyc = 0, cap_cnt = 0;
  int          err_rise_cyc = 0, err_fall_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial forever @(posedge clk) cyc++;

  // UART side: a read pops the FIFO and returns the byte one cycle later
  initial begin
    logic rd;
    busOutEn = 1'b0; busDataIn = '0; rxFfEmpty = 1'b1;
    forever begin
      @(negedge clk);
      rd = busRdEn;
      @(posedge clk);
      #1;
      if (rd) check("rd_nonempty", 64'(rx_q.size() != 0), 64'd1);
      if (rd && rx_q.size() != 0) begin
        busOutEn  = 1'b1;
        busDataIn = {$urandom_range(0, 32'hFFFF_FF), rx_q.pop_front()};
      end else begin
        busOutEn  = 1'b0;
        busDataIn = $urandom();
      end
      rxFfEmpty = (rx_q.size() == 0);
    end
  end

  // Frame-level expectation: scan for SYNC, decode length, assemble words.
  function automatic void model_stream(input logic [7:0] s[$]);
    int i = 0;
    int len;
    logic [7:0] ck;
    exp_done = 1'b0;
    exp_error = 1'b0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin i++; continue; end
      if (i + 2 >= s.size()) break;
      exp_error = 1'b0;
      len = int'(s[i+1]) + 256 * int'(s[i+2]);
      ck  = s[i+1] ^ s[i+2];
      i  += 3;
      if (len > 1024) begin exp_error = 1'b1; continue; end
      if (i + 4 * len >= s.size()) break;
      for (int w = 0; w < len; w++) begin
        exp_wr.push_back('{addr: 10'(w), data: {s[i+3], s[i+2], s[i+1], s[i]}});
        ck = ck ^ s[i] ^ s[i+1] ^ s[i+2] ^ s[i+3];
        i += 4;
      end
      if (s[i] == ck) begin exp_done = 1'b1; break; end
      exp_error = 1'b1;
      i++;
    end
  endfunction

  // Monitor: per-cycle comparison against the model and timing rules
  initial begin
    logic prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;
    wr_t  e;
    forever begin
      @(negedge clk);
      check("hold_vs_done", 64'(cpuHold), 64'(!done));
      if (!rst) begin
        if (busOutEn) begin
          cap_cnt++;
          last_cap_cyc = cyc;
          if (busDataIn[7:0] == 8'hA5) sync_cap_cyc = cyc;
        end
        if (imemWrEn) begin
          check("wr_not_back_to_back", 64'(prev_we), 64'd0);
          act_wr.push_back('{addr: imemAddr, data: imemWrData});
          if (exp_wr.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected none", imemAddr, imemWrData);
          end else begin
            e = exp_wr.pop_front();
            check("wr_addr", 64'(imemAddr), 64'(e.addr));
            check("wr_data", 64'(imemWrData), 64'(e.data));
          end
        end
        if (busy) check("busy_excl_done", 64'(done), 64'd0);
        if (done && !prev_done) check("done_latency", 64'(cyc - last_cap_cyc), 64'd1);
        if (error && !prev_err) err_rise_cyc = cyc;
        if (!error && prev_err) err_fall_cyc = cyc;
      end
      prev_we = imemWrEn; prev_done = done; prev_err = error;
    end
  end

  task automatic run_bytes(input logic [7:0] s[$], input string name);
    int n = 0;
    int budget = 3 * s.size() + 30;
    @(negedge clk);
    foreach (s[k]) rx_q.push_back(s[k]);
    @(negedge clk);
    while ((rx_q.size() != 0 || busRdEn || busOutEn) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 64'(n < budget), 64'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_restart();
    @(posedge clk); #1 restart = 1'b1;
    @(posedge clk); #1 restart = 1'b0;
    @(negedge clk);
    check("restart_done", 64'(done), 64'd0);
    check("restart_hold", 64'(cpuHold), 64'd1);
    check("restart_busy", 64'(busy), 64'd0);
    check("restart_error", 64'(error), 64'd0);
    act_wr.delete();
  endtask

  task automatic check_end(input string name);
    check({name, "_done"}, 64'(done), 64'(exp_done));
    check({name, "_error"}, 64'(error), 64'(exp_error));
    check({name, "_hold"}, 64'(cpuHold), 64'(!exp_done));
    check({name, "_all_writes"}, 64'(exp_wr.size()), 64'd0);
  endtask

  task automatic check_frame_a_words(input string name);
    check({name, "_nwr"}, 64'(act_wr.size()), 64'd2);
    if (act_wr.size() >= 2) begin
      check({name, "_w0_addr"}, 64'(act_wr[0].addr), 64'd0);
      check({name, "_w0_data"}, 64'(act_wr[0].data), 64'h4433_2211);
      check({name, "_w1_addr"}, 64'(act_wr[1].addr), 64'd1);
      check({name, "_w1_data"}, 64'(act_wr[1].data), 64'hDDCC_BBAA);
    end
  endtask

  logic [7:0] frame_a[$] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
  logic [7:0] frame_bad[$] = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                               8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};
  logic [7:0] garbage_a[$] = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'h00, 8'h11,
                               8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
  logic [7:0] frame_zero[$] = '{8'hA5, 8'h00, 8'h00, 8'h00};
  logic [7:0] frame_big[$]  = '{8'hA5, 8'h01, 8'h04};
  logic [7:0] frame_stall[$] = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
  logic [7:0] frame_drop[$]  = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'hA5};

  initial begin
    int n;
    int base;
    rst = 1'b1; restart = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busRdEn", 64'(busRdEn), 64'd0);
    check("rst_imemWrEn", 64'(imemWrEn), 64'd0);
    check("rst_imemAddr", 64'(imemAddr), 64'd0);
    check("rst_imemWrData", 64'(imemWrData), 64'd0);
    check("rst_cpuHold", 64'(cpuHold), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("busAddr", 64'(busAddr), 64'h402);
    @(posedge clk); #1 rst = 1'b0;

    // valid frame
    model_stream(frame_a);
    run_bytes(frame_a, "frame_a");
    check_end("frame_a");
    check_frame_a_words("frame_a");
    check("frame_a_done_lit", 64'(done), 64'd1);

    // leading garbage is discarded
    pulse_restart();
    model_stream(garbage_a);
    run_bytes(garbage_a, "garbage");
    check_end("garbage");
    check_frame_a_words("garbage");

    // bad checksum, then a valid frame without restart
    pulse_restart();
    model_stream(frame_bad);
    run_bytes(frame_bad, "bad_ck");
    check_end("bad_ck");
    check("bad_ck_error_lit", 64'(error), 64'd1);
    check_frame_a_words("bad_ck");
    act_wr.delete();
    model_stream(frame_a);
    run_bytes(frame_a, "after_bad");
    check_end("after_bad");
    check("error_clears_at_sync", 64'(err_fall_cyc - sync_cap_cyc), 64'd1);

    // zero-length image
    pulse_restart();
    model_stream(frame_zero);
    run_bytes(frame_zero, "zero_len");
    check_end("zero_len");
    check("zero_len_nwr", 64'(act_wr.size()), 64'd0);

    // oversize length rejected right after LEN_HI
    pulse_restart();
    model_stream(frame_big);
    run_bytes(frame_big, "too_long");
    check("too_long_error_lit", 64'(error), 64'd1);
    check("too_long_latency", 64'(err_rise_cyc - last_cap_cyc), 64'd1);
    check("too_long_nwr", 64'(act_wr.size()), 64'd0);
    check("too_long_done", 64'(done), 64'd0);

    // stall mid-data: timeout 1000 cycles after the last capture
    pulse_restart();
    run_bytes(frame_stall, "stall");
    check("stall_busy", 64'(busy), 64'd1);
    n = 0;
    while (!error && n < 1200) begin @(negedge clk); n++; end
    check("stall_error_seen", 64'(error), 64'd1);
    check("stall_timeout_cycles", 64'(err_rise_cyc - last_cap_cyc), 64'd1000);
    check("stall_nwr", 64'(act_wr.size()), 64'd0);

    // restart coinciding with the return of an outstanding SYNC-valued byte
    pulse_restart();
    base = cap_cnt;
    @(negedge clk);
    foreach (frame_drop[k]) rx_q.push_back(frame_drop[k]);
    n = 0;
    while (cap_cnt < base + 4 && n < 60) begin @(negedge clk); n++; end
    while (!busRdEn && n < 60) begin @(negedge clk); n++; end
    check("drop_read_issued", 64'(busRdEn), 64'd1);
    pulse_restart();
    check("drop_fifo_empty", 64'(rx_q.size()), 64'd0);
    model_stream(frame_a);
    run_bytes(frame_a, "after_drop");
    check_end("after_drop");
    check_frame_a_words("after_drop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_loader.md
# uart_loader

Boot-time program loader sitting directly downstream of the UART peripheral. It acts as a bus master on the UART register port and drains received bytes from the UDR receive FIFO. It parses a framed binary image and writes assembled 32-bit words into instruction memory. While the CPU core is loading it holds the core in reset, and releases it once a frame has been accepted.

## Interface
Parameters:
- `UDR_ADDR`, 11'h402: UART data register address used for reads.
- `IMEM_AW`, 10: instruction-memory word-address width; max image = 2**IMEM_AW words.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000: max clk cycles between bytes inside a frame.

Ports:
- `clk` in 1: clock; one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `restart` in 1: synchronous re-arm pulse.
- `rxFfEmpty` in 1: UART receive FIFO empty.
- `busAddr` out 11: constant `UDR_ADDR`.
- `busRdEn` out 1: one-cycle read strobe to the UART.
- `busDataIn` in 32: UART read data; bits [7:0] are valid when `busOutEn` is high.
- `busOutEn` in 1: read data valid; arrives 1 cycle after `busRdEn`.
- `imemAddr` out IMEM_AW: word address.
- `imemWrData` out 32: word data.
- `imemWrEn` out 1: one-cycle write strobe.
- `cpuHold` out 1: holds the core in reset.
- `busy` out 1: a frame is in progress.
- `done` out 1: an image was loaded successfully.
- `error` out 1: the last frame was rejected.

## Operation
- Frame format: SYNC, LEN_LO, LEN_HI, then LEN words of 4 bytes each (LSB byte first), then CKSUM.
- CKSUM is the XOR of every byte after SYNC (both LEN bytes and all data bytes).
- Read engine:
  - Issue `busRdEn` only when `rxFfEmpty`=0, no read is outstanding, and the engine is not in the post-capture idle cycle.
  - Capture `busDataIn[7:0]` on `busOutEn`.
  - Stay idle for 1 cycle after each capture so the empty flag can settle. Peak rate is 1 byte per 3 cycles.
- States:
  - WAIT_SYNC: bytes other than SYNC_BYTE are discarded. SYNC -> LEN_LO, which clears the checksum, word count, byte index and `error`.
  - LEN_LO: capture the low length byte -> LEN_HI.
  - LEN_HI: capture the high length byte.
    - LEN = 0 -> CKSUM.
    - LEN > 2**IMEM_AW -> ERROR.
    - Otherwise -> DATA.
  - DATA: bytes fill the word LSB first. On the 4th byte, the word is written and the word count increments. After LEN words -> CKSUM.
  - CKSUM: received byte equals the running XOR -> DONE; mismatch -> ERROR.
  - DONE: `done`=1, `cpuHold`=0, no further reads. Held until `restart` or `rst`.
  - ERROR: `error`=1 for one cycle in this state -> WAIT_SYNC. `error` stays high until the next SYNC is accepted.
- Timeout:
  - An inter-byte counter runs in LEN_LO..CKSUM and resets on every capture.
  - Reaching TIMEOUT_CYCLES -> ERROR.
  - The counter is inactive in WAIT_SYNC, DONE and ERROR.
- `busy` = state in {LEN_LO, LEN_HI, DATA, CKSUM}.
- `restart` from any state:
  - Go to WAIT_SYNC and clear `done`, `error` and all counters; `cpuHold`=1.
  - If a read is outstanding, its returning byte is dropped.
  - `rst` has the same effect and additionally clears the outputs listed under Timing.
- Width rules:
  - LEN is 16 bits.
  - The word counter is IMEM_AW+1 bits, so a full image of 2**IMEM_AW words is legal.
  - `imemAddr` is the word counter's low IMEM_AW bits.

## Timing
- Reset values: `busRdEn`=0, `imemWrEn`=0, `imemAddr`=0, `imemWrData`=0, `cpuHold`=1, `busy`=0, `done`=0, `error`=0, state WAIT_SYNC.
- `busRdEn` is registered. The byte is captured in the cycle `busOutEn`=1, i.e. 1 cycle after `busRdEn`.
- `imemWrEn` rises 1 cycle after capture of a word's 4th byte, with `imemAddr` and `imemWrData` stable in the same cycle. It is never asserted on two consecutive cycles.
- `done`/`cpuHold` change 1 cycle after the CKSUM byte is captured.
- A simultaneous `restart` and `busOutEn`: `restart` wins and the byte is dropped.

## Test plan
- Valid frame A5 02 00 11 22 33 44 AA BB CC DD 46:
  - writes 0x44332211 @0, then 0xDDCCBBAA @1;
  - `done`=1, `cpuHold`=0, `error`=0.
- Garbage 00 FF 5A, then the same frame: garbage is ignored and the result is identical; no `imemWrEn` occurs before SYNC.
- Same frame with CKSUM 47:
  - `error`=1, `done`=0, `cpuHold`=1 (both words were written);
  - a following valid frame clears `error` at SYNC and ends with `done`=1.
- A5 00 00 00: zero `imemWrEn` pulses, `done`=1.
- A5 01 04 (LEN 0x0401 > 1024 with IMEM_AW=10): ERROR immediately after LEN_HI, with no writes.
- TIMEOUT_CYCLES=1000; send A5 01 00 11 22, then stall:
  - `error` rises 1000 cycles after the 0x22 capture;
  - separately, `restart` asserted mid-DATA with a read outstanding returns to WAIT_SYNC and drops that byte.
